// File: rtl/multi_commit_rob.sv
// Reorder buffer with count-based occupancy and up to two in-order commits per cycle.
// It also bypasses same-cycle writebacks to operand lookups and stalls stores at head until the LSB accepts them.
module multi_commit_rob #(
  parameter int ROB_WIDTH   = 4,
  parameter int DUAL_COMMIT = 1
) (
  input  logic                   clockIn,
  input  logic                   resetIn,
  input  logic                   readyIn,
  output logic                   clear,
  output logic [31:0]            setPCVal,
  input  logic                   addFlag,
  input  logic [1:0]             addType,
  input  logic [4:0]             addDest,
  input  logic                   addJump,
  input  logic [31:0]            addPC,
  input  logic [31:0]            addInsAddr,
  input  logic                   addValueFlag,
  input  logic [31:0]            addValue,
  output logic [ROB_WIDTH-1:0]   freeId,
  output logic                   full,
  output logic [ROB_WIDTH:0]     count,
  input  logic [ROB_WIDTH-1:0]   rs1Id,
  input  logic [ROB_WIDTH-1:0]   rs2Id,
  output logic                   rs1Busy,
  output logic                   rs2Busy,
  output logic [31:0]            rs1Val,
  output logic [31:0]            rs2Val,
  input  logic                   rsFlag,
  input  logic [ROB_WIDTH-1:0]   rsId,
  input  logic [31:0]            rsValue,
  input  logic                   loadFlag,
  input  logic [ROB_WIDTH-1:0]   loadId,
  input  logic [31:0]            loadValue,
  output logic                   predictFlag,
  output logic [31:0]            predictAddr,
  output logic                   predictVal,
  output logic [1:0]             rfFlag,
  output logic [2*ROB_WIDTH-1:0] rfRobId,
  output logic [9:0]             rfDest,
  output logic [63:0]            rfValue,
  output logic                   storeFlag,
  output logic [ROB_WIDTH-1:0]   storeId,
  input  logic                   storeAccept,
  output logic [ROB_WIDTH-1:0]   headId
);
  localparam int                 ROB_SIZE = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] SIZE_CNT = (ROB_WIDTH + 1)'(ROB_SIZE);
  localparam logic               DUAL_EN  = (DUAL_COMMIT != 0);
  localparam logic [1:0]         T_BRANCH = 2'b10;
  localparam logic [1:0]         T_STORE  = 2'b11;

  function automatic logic is_other(input logic [1:0] t);
    return (t != T_BRANCH) && (t != T_STORE);
  endfunction

  logic [ROB_SIZE-1:0]  busy_q, ready_q, jump_q;
  logic [1:0]           type_q [ROB_SIZE];
  logic [4:0]           dest_q [ROB_SIZE];
  logic [31:0]          pc_q   [ROB_SIZE];
  logic [31:0]          ins_q  [ROB_SIZE];
  logic [31:0]          val_q  [ROB_SIZE];
  logic [ROB_WIDTH-1:0] head_q, tail_q, head1;
  logic [ROB_WIDTH:0]   count_q;
  logic                 flush, do_alloc, c0, c1;
  logic [1:0]           type0, type1;
  logic [1:0]           rf_flag_p1;
  logic [ROB_WIDTH-1:0] rf_id0_p1, rf_id1_p1;
  logic [4:0]           rf_dest0_p1, rf_dest1_p1;
  logic [31:0]          rf_val0_p1, rf_val1_p1;

  assign flush    = resetIn || (clear && readyIn);
  assign head1    = head_q + ROB_WIDTH'(1);
  assign full     = (count_q == SIZE_CNT);
  assign do_alloc = addFlag && !full;
  assign type0    = type_q[head_q];
  assign type1    = type_q[head1];

  // Slot1 only follows an OTHER in slot0, so at most one store or branch leaves per cycle.
  assign c0 = busy_q[head_q] && ready_q[head_q] && ((type0 != T_STORE) || storeAccept);
  assign c1 = DUAL_EN && c0 && is_other(type0) && busy_q[head1] && ready_q[head1] &&
              (is_other(type1) || ((type1 == T_STORE) && storeAccept));

  always_comb begin
    rs1Busy = busy_q[rs1Id] && !ready_q[rs1Id];
    rs1Val  = val_q[rs1Id];
    if (rsFlag && (rsId == rs1Id)) begin
      rs1Busy = 1'b0;
      rs1Val  = rsValue;
    end else if (loadFlag && (loadId == rs1Id)) begin
      rs1Busy = 1'b0;
      rs1Val  = loadValue;
    end
    rs2Busy = busy_q[rs2Id] && !ready_q[rs2Id];
    rs2Val  = val_q[rs2Id];
    if (rsFlag && (rsId == rs2Id)) begin
      rs2Busy = 1'b0;
      rs2Val  = rsValue;
    end else if (loadFlag && (loadId == rs2Id)) begin
      rs2Busy = 1'b0;
      rs2Val  = loadValue;
    end
  end

  always_ff @(posedge clockIn) begin
    if (flush) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      ready_q     <= '0;
      clear       <= 1'b0;
      setPCVal    <= '0;
      predictFlag <= 1'b0;
      predictAddr <= '0;
      predictVal  <= 1'b0;
      rf_flag_p1  <= '0;
      rf_id0_p1   <= '0;
      rf_id1_p1   <= '0;
      rf_dest0_p1 <= '0;
      rf_dest1_p1 <= '0;
      rf_val0_p1  <= '0;
      rf_val1_p1  <= '0;
      storeFlag   <= 1'b0;
      storeId     <= '0;
    end else if (readyIn) begin
      if (do_alloc) begin
        busy_q[tail_q]  <= 1'b1;
        ready_q[tail_q] <= addValueFlag;
        tail_q          <= tail_q + ROB_WIDTH'(1);
      end
      if (loadFlag) ready_q[loadId] <= 1'b1;
      if (rsFlag)   ready_q[rsId]   <= 1'b1;
      if (c0)       busy_q[head_q]  <= 1'b0;
      if (c1)       busy_q[head1]   <= 1'b0;
      head_q  <= head_q + ROB_WIDTH'(c0) + ROB_WIDTH'(c1);
      count_q <= count_q + (ROB_WIDTH + 1)'(do_alloc) - (ROB_WIDTH + 1)'(c0) - (ROB_WIDTH + 1)'(c1);

      // commit decision -> registered commit outputs
      rf_flag_p1 <= {c1 && is_other(type1), c0 && is_other(type0)};
      if (c0 && is_other(type0)) begin
        rf_id0_p1   <= head_q;
        rf_dest0_p1 <= dest_q[head_q];
        rf_val0_p1  <= val_q[head_q];
      end
      if (c1 && is_other(type1)) begin
        rf_id1_p1   <= head1;
        rf_dest1_p1 <= dest_q[head1];
        rf_val1_p1  <= val_q[head1];
      end
      storeFlag <= (c0 && (type0 == T_STORE)) || (c1 && (type1 == T_STORE));
      if (c0 && (type0 == T_STORE))      storeId <= head_q;
      else if (c1 && (type1 == T_STORE)) storeId <= head1;
      predictFlag <= c0 && (type0 == T_BRANCH);
      clear       <= c0 && (type0 == T_BRANCH) && (val_q[head_q][0] ^ jump_q[head_q]);
      if (c0 && (type0 == T_BRANCH)) begin
        predictAddr <= ins_q[head_q];
        predictVal  <= val_q[head_q][0];
        setPCVal    <= pc_q[head_q];
      end
    end
  end

  always_ff @(posedge clockIn) begin
    if (readyIn && !flush) begin
      if (do_alloc) begin
        type_q[tail_q] <= addType;
        dest_q[tail_q] <= addDest;
        jump_q[tail_q] <= addJump;
        pc_q[tail_q]   <= addPC;
        ins_q[tail_q]  <= addInsAddr;
        val_q[tail_q]  <= addValue;
      end
      if (loadFlag) val_q[loadId] <= loadValue;
      if (rsFlag)   val_q[rsId]   <= rsValue;
    end
  end

  assign freeId  = tail_q;
  assign count   = count_q;
  assign headId  = head_q;
  assign rfFlag  = {rf_flag_p1[1] & DUAL_EN, rf_flag_p1[0]};
  assign rfRobId = {rf_id1_p1 & {ROB_WIDTH{DUAL_EN}}, rf_id0_p1};
  assign rfDest  = {rf_dest1_p1 & {5{DUAL_EN}}, rf_dest0_p1};
  assign rfValue = {rf_val1_p1 & {32{DUAL_EN}}, rf_val0_p1};
endmodule

// File: tb/tb_multi_commit_rob.sv
// Bench for multi_commit_rob: directed scenarios plus a randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_multi_commit_rob;
  localparam int RS = 16;
  localparam logic [1:0] T_OTHER = 2'b00, T_BRANCH = 2'b10, T_STORE = 2'b11;

  logic clk;
  logic resetIn, readyIn, clear, addFlag, addJump, addValueFlag, full;
  logic [31:0] setPCVal, addPC, addInsAddr, addValue;
  logic [1:0]  addType;
  logic [4:0]  addDest;
  logic [3:0]  freeId, rs1Id, rs2Id, rsId, loadId, storeId, headId;
  logic [4:0]  count;
  logic        rs1Busy, rs2Busy, rsFlag, loadFlag, predictFlag, predictVal, storeFlag, storeAccept;
  logic [31:0] rs1Val, rs2Val, rsValue, loadValue, predictAddr;
  logic [1:0]  rfFlag;
  logic [7:0]  rfRobId;
  logic [9:0]  rfDest;
  logic [63:0] rfValue;
  int n_checks = 0;
  int n_fail = 0;

  multi_commit_rob #(.ROB_WIDTH(4), .DUAL_COMMIT(1)) dut (
    .clockIn(clk), .resetIn(resetIn), .readyIn(readyIn), .clear(clear), .setPCVal(setPCVal),
    .addFlag(addFlag), .addType(addType), .addDest(addDest), .addJump(addJump), .addPC(addPC),
    .addInsAddr(addInsAddr), .addValueFlag(addValueFlag), .addValue(addValue),
    .freeId(freeId), .full(full), .count(count), .rs1Id(rs1Id), .rs2Id(rs2Id),
    .rs1Busy(rs1Busy), .rs2Busy(rs2Busy), .rs1Val(rs1Val), .rs2Val(rs2Val),
    .rsFlag(rsFlag), .rsId(rsId), .rsValue(rsValue), .loadFlag(loadFlag), .loadId(loadId),
    .loadValue(loadValue), .predictFlag(predictFlag), .predictAddr(predictAddr),
    .predictVal(predictVal), .rfFlag(rfFlag), .rfRobId(rfRobId), .rfDest(rfDest),
    .rfValue(rfValue), .storeFlag(storeFlag), .storeId(storeId), .storeAccept(storeAccept),
    .headId(headId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    readyIn = 1'b1; addFlag = 1'b0; addType = T_OTHER; addDest = '0; addJump = 1'b0;
    addPC = '0; addInsAddr = '0; addValueFlag = 1'b0; addValue = '0;
    rs1Id = '0; rs2Id = '0; rsFlag = 1'b0; rsId = '0; rsValue = '0;
    loadFlag = 1'b0; loadId = '0; loadValue = '0; storeAccept = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetIn = 1'b1;
    tick();
    tick();
    resetIn = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b expected 0", full); end
    n_checks++; if (freeId !== 4'd0 || headId !== 4'd0) begin n_fail++; $display("FAIL reset_ptrs: got tail %0d head %0d expected 0 0", freeId, headId); end
    n_checks++; if (clear !== 1'b0 || setPCVal !== 32'd0) begin n_fail++; $display("FAIL reset_clear: got %0b %0h expected 0 0", clear, setPCVal); end
    n_checks++; if (predictFlag !== 1'b0 || predictAddr !== 32'd0 || predictVal !== 1'b0) begin n_fail++; $display("FAIL reset_predict: got %0b %0h %0b expected 0", predictFlag, predictAddr, predictVal); end
    n_checks++; if (rfFlag !== 2'd0 || rfRobId !== 8'd0 || rfDest !== 10'd0 || rfValue !== 64'd0) begin n_fail++; $display("FAIL reset_rf: got %0b %0h %0h %0h expected 0", rfFlag, rfRobId, rfDest, rfValue); end
    n_checks++; if (storeFlag !== 1'b0 || storeId !== 4'd0) begin n_fail++; $display("FAIL reset_store: got %0b %0d expected 0", storeFlag, storeId); end
  endtask

  task automatic test_fill_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      addFlag = 1'b1; addType = T_OTHER; addDest = 5'(i); addValueFlag = 1'b0; addValue = 32'(i);
      tick();
    end
    #1;
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %0b expected 1", full); end
    n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL fill_count: got %0d expected 16", count); end
    n_checks++; if (freeId !== 4'd0) begin n_fail++; $display("FAIL fill_tail: got %0d expected 0", freeId); end
    tick();
    addFlag = 1'b0;
    n_checks++; if (count !== 5'd16 || freeId !== 4'd0) begin n_fail++; $display("FAIL fill_overflow: got count %0d tail %0d expected 16 0", count, freeId); end
    rs1Id = 4'd5;
    #1;
    n_checks++; if (rs1Busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy: got %0b expected 1", rs1Busy); end
  endtask

  task automatic test_bypass();
    readyIn = 1'b0;
    rsFlag = 1'b1; rsId = 4'd3; rsValue = 32'hDEAD_BEEF; rs1Id = 4'd3;
    loadFlag = 1'b1; loadId = 4'd7; loadValue = 32'h1234_5678; rs2Id = 4'd7;
    #1;
    n_checks++; if (rs1Busy !== 1'b0 || rs1Val !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_rs: got %0b %0h expected 0 deadbeef", rs1Busy, rs1Val); end
    n_checks++; if (rs2Busy !== 1'b0 || rs2Val !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_load: got %0b %0h expected 0 12345678", rs2Busy, rs2Val); end
    rsId = 4'd9; rsValue = 32'hA5A5_A5A5; loadId = 4'd9; loadValue = 32'h5A5A_5A5A; rs1Id = 4'd9; rs2Id = 4'd4;
    #1;
    n_checks++; if (rs1Busy !== 1'b0 || rs1Val !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL bypass_prio: got %0b %0h expected 0 a5a5a5a5", rs1Busy, rs1Val); end
    n_checks++; if (rs2Busy !== 1'b1) begin n_fail++; $display("FAIL bypass_other: got %0b expected 1", rs2Busy); end
    tick();
    n_checks++; if (count !== 5'd16 || rfFlag !== 2'd0) begin n_fail++; $display("FAIL hold: got count %0d rf %0b expected 16 0", count, rfFlag); end
    idle();
  endtask

  task automatic test_dual_commit();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      addFlag = 1'b1; addType = T_OTHER; addDest = 5'(10 + i); addValueFlag = 1'b0;
      tick();
    end
    addFlag = 1'b0;
    rsFlag = 1'b1; rsId = 4'd0; rsValue = 32'h100;
    loadFlag = 1'b1; loadId = 4'd1; loadValue = 32'h101;
    tick();
    idle();
    n_checks++; if (rfFlag !== 2'd0 || count !== 5'd3) begin n_fail++; $display("FAIL dual_pre: got rf %0b count %0d expected 0 3", rfFlag, count); end
    tick();
    n_checks++; if (rfFlag !== 2'b11) begin n_fail++; $display("FAIL dual_flag: got %0b expected 11", rfFlag); end
    n_checks++; if (rfRobId !== 8'h10 || rfDest !== {5'd11, 5'd10}) begin n_fail++; $display("FAIL dual_ids: got %0h %0h expected 10 %0h", rfRobId, rfDest, {5'd11, 5'd10}); end
    n_checks++; if (rfValue !== {32'h101, 32'h100}) begin n_fail++; $display("FAIL dual_val: got %0h expected 0000010100000100", rfValue); end
    n_checks++; if (headId !== 4'd2 || count !== 5'd1) begin n_fail++; $display("FAIL dual_head: got head %0d count %0d expected 2 1", headId, count); end
    tick();
    n_checks++; if (rfFlag !== 2'd0) begin n_fail++; $display("FAIL dual_pulse: got %0b expected 0", rfFlag); end
  endtask

  task automatic test_store_backpressure();
    do_reset();
    addFlag = 1'b1; addType = T_STORE; addValueFlag = 1'b1; addValue = 32'h55; storeAccept = 1'b0;
    tick();
    addFlag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (storeFlag !== 1'b0 || headId !== 4'd0) begin n_fail++; $display("FAIL store_stall%0d: got %0b head %0d expected 0 0", i, storeFlag, headId); end
    end
    storeAccept = 1'b1;
    tick();
    n_checks++; if (storeFlag !== 1'b1 || storeId !== 4'd0) begin n_fail++; $display("FAIL store_go: got %0b id %0d expected 1 0", storeFlag, storeId); end
    n_checks++; if (headId !== 4'd1 || count !== 5'd0) begin n_fail++; $display("FAIL store_head: got %0d %0d expected 1 0", headId, count); end
    storeAccept = 1'b0;
    tick();
    n_checks++; if (storeFlag !== 1'b0) begin n_fail++; $display("FAIL store_pulse: got %0b expected 0", storeFlag); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    addFlag = 1'b1; addType = T_BRANCH; addJump = 1'b0; addValueFlag = 1'b1; addValue = 32'd1;
    addPC = 32'h104; addInsAddr = 32'h100;
    tick();
    addType = T_OTHER; addDest = 5'd3; addValueFlag = 1'b0; addPC = '0; addInsAddr = '0;
    tick();
    idle();
    n_checks++; if (clear !== 1'b1 || setPCVal !== 32'h104) begin n_fail++; $display("FAIL br_clear: got %0b %0h expected 1 104", clear, setPCVal); end
    n_checks++; if (predictFlag !== 1'b1 || predictAddr !== 32'h100 || predictVal !== 1'b1) begin n_fail++; $display("FAIL br_predict: got %0b %0h %0b expected 1 100 1", predictFlag, predictAddr, predictVal); end
    n_checks++; if (headId !== 4'd1 || count !== 5'd1) begin n_fail++; $display("FAIL br_head: got %0d %0d expected 1 1", headId, count); end
    tick();
    n_checks++; if (headId !== 4'd0 || freeId !== 4'd0 || count !== 5'd0) begin n_fail++; $display("FAIL br_flush: got %0d %0d %0d expected 0 0 0", headId, freeId, count); end
    n_checks++; if (clear !== 1'b0 || predictFlag !== 1'b0 || rfFlag !== 2'd0 || storeFlag !== 1'b0 || setPCVal !== 32'd0) begin n_fail++; $display("FAIL br_flags: got %0b %0b %0b %0b %0h expected 0", clear, predictFlag, rfFlag, storeFlag, setPCVal); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      addFlag = 1'b1; addType = T_OTHER; addValueFlag = 1'b1; addValue = 32'(i); addDest = 5'd1;
      tick();
    end
    idle();
    tick();
    tick();
    n_checks++; if (headId !== 4'd15 || freeId !== 4'd15 || count !== 5'd0) begin n_fail++; $display("FAIL wrap_pre: got %0d %0d %0d expected 15 15 0", headId, freeId, count); end
    addFlag = 1'b1; addValueFlag = 1'b0; addDest = 5'd20;
    tick();
    addDest = 5'd21;
    tick();
    addFlag = 1'b0;
    n_checks++; if (freeId !== 4'd1 || count !== 5'd2) begin n_fail++; $display("FAIL wrap_tail: got %0d %0d expected 1 2", freeId, count); end
    rsFlag = 1'b1; rsId = 4'd15; rsValue = 32'hAAAA_0001;
    loadFlag = 1'b1; loadId = 4'd0; loadValue = 32'hBBBB_0002;
    tick();
    idle();
    tick();
    n_checks++; if (rfFlag !== 2'b11 || rfRobId !== 8'h0F) begin n_fail++; $display("FAIL wrap_ids: got %0b %0h expected 11 0f", rfFlag, rfRobId); end
    n_checks++; if (rfValue !== {32'hBBBB_0002, 32'hAAAA_0001} || rfDest !== {5'd21, 5'd20}) begin n_fail++; $display("FAIL wrap_data: got %0h %0h", rfValue, rfDest); end
    n_checks++; if (headId !== 4'd1 || count !== 5'd0) begin n_fail++; $display("FAIL wrap_head: got %0d %0d expected 1 0", headId, count); end
  endtask

  task automatic test_random();
    logic [1:0]  m_type [RS];
    logic [4:0]  m_dest [RS];
    logic        m_jump [RS];
    logic [31:0] m_pc [RS];
    logic [31:0] m_ins [RS];
    logic [31:0] m_val [RS];
    logic        m_ready [RS];
    int          q[$];
    int          m_head, m_tail;
    logic        e_clear, e_pf, e_pv, e_sf;
    logic [31:0] e_setpc, e_pa;
    logic [1:0]  e_rf;
    logic [3:0]  e_rid [2];
    logic [4:0]  e_rd [2];
    logic [31:0] e_rv [2];
    logic [3:0]  e_sid;
    do_reset();
    m_head = 0; m_tail = 0; q.delete();
    e_clear = 0; e_pf = 0; e_pv = 0; e_sf = 0; e_setpc = 0; e_pa = 0; e_rf = 0; e_sid = 0;
    for (int i = 0; i < RS; i++) m_ready[i] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int cand[$];
      int pick, r;
      bit full_now, c0, c1;
      int h0, h1;
      readyIn = ($urandom_range(0, 9) != 0);
      storeAccept = ($urandom_range(0, 2) != 0);
      addFlag = ($urandom_range(0, 9) < 6);
      r = $urandom_range(0, 19);
      addType = (r < 14) ? T_OTHER : ((r < 17) ? T_STORE : T_BRANCH);
      addDest = 5'($urandom); addJump = 1'($urandom); addPC = $urandom; addInsAddr = $urandom;
      addValueFlag = ($urandom_range(0, 2) == 0); addValue = $urandom;
      rs1Id = 4'($urandom); rs2Id = 4'($urandom);
      cand.delete();
      foreach (q[k]) if (!m_ready[q[k]]) cand.push_back(q[k]);
      rsFlag = 1'b0; loadFlag = 1'b0;
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, cand.size() - 1);
        rsFlag = 1'b1; rsId = 4'(cand[pick]); rsValue = $urandom; cand.delete(pick);
      end
      if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
        pick = $urandom_range(0, cand.size() - 1);
        loadFlag = 1'b1; loadId = 4'(cand[pick]); loadValue = $urandom;
      end
      #1;
      full_now = (q.size() == RS);
      n_checks++; if (count !== 5'(q.size()) || full !== full_now) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d %0b expected %0d %0b", cyc, count, full, q.size(), full_now); end
      n_checks++; if (headId !== 4'(m_head) || freeId !== 4'(m_tail)) begin n_fail++; $display("FAIL rnd_ptrs c%0d: got %0d %0d expected %0d %0d", cyc, headId, freeId, m_head, m_tail); end
      for (int p = 0; p < 2; p++) begin
        logic [3:0] lid;
        logic gb, eb, vk, inq;
        logic [31:0] gv, ev;
        lid = p ? rs2Id : rs1Id; gb = p ? rs2Busy : rs1Busy; gv = p ? rs2Val : rs1Val;
        inq = 1'b0;
        foreach (q[k]) if (q[k] == int'(lid)) inq = 1'b1;
        if (rsFlag && rsId == lid) begin eb = 1'b0; ev = rsValue; vk = 1'b1; end
        else if (loadFlag && loadId == lid) begin eb = 1'b0; ev = loadValue; vk = 1'b1; end
        else begin eb = inq && !m_ready[lid]; ev = m_val[lid]; vk = inq && m_ready[lid]; end
        n_checks++; if (gb !== eb) begin n_fail++; $display("FAIL rnd_busy%0d c%0d: got %0b expected %0b", p, cyc, gb, eb); end
        if (vk) begin
          n_checks++; if (gv !== ev) begin n_fail++; $display("FAIL rnd_val%0d c%0d: got %0h expected %0h", p, cyc, gv, ev); end
        end
      end
      if (readyIn) begin
        if (e_clear) begin
          q.delete(); m_head = 0; m_tail = 0;
          for (int i = 0; i < RS; i++) m_ready[i] = 1'b0;
          e_clear = 0; e_pf = 0; e_sf = 0; e_rf = 0;
        end else begin
          c0 = 0; c1 = 0; h0 = 0; h1 = 0;
          if (q.size() > 0) begin
            h0 = q[0];
            c0 = m_ready[h0] && (m_type[h0] != T_STORE || storeAccept);
          end
          if (c0 && m_type[h0] == T_OTHER && q.size() > 1) begin
            h1 = q[1];
            c1 = m_ready[h1] && (m_type[h1] == T_OTHER || (m_type[h1] == T_STORE && storeAccept));
          end
          e_rf = 0; e_sf = 0; e_pf = 0; e_clear = 0;
          if (c0) begin
            if (m_type[h0] == T_OTHER) begin e_rf[0] = 1; e_rid[0] = 4'(h0); e_rd[0] = m_dest[h0]; e_rv[0] = m_val[h0]; end
            else if (m_type[h0] == T_STORE) begin e_sf = 1; e_sid = 4'(h0); end
            else begin e_pf = 1; e_pa = m_ins[h0]; e_pv = m_val[h0][0]; e_clear = m_val[h0][0] ^ m_jump[h0]; e_setpc = m_pc[h0]; end
          end
          if (c1) begin
            if (m_type[h1] == T_OTHER) begin e_rf[1] = 1; e_rid[1] = 4'(h1); e_rd[1] = m_dest[h1]; e_rv[1] = m_val[h1]; end
            else begin e_sf = 1; e_sid = 4'(h1); end
          end
          if (c0) void'(q.pop_front());
          if (c1) void'(q.pop_front());
          m_head = (m_head + int'(c0) + int'(c1)) % RS;
          if (addFlag && !full_now) begin
            m_type[m_tail] = addType; m_dest[m_tail] = addDest; m_jump[m_tail] = addJump;
            m_pc[m_tail] = addPC; m_ins[m_tail] = addInsAddr; m_val[m_tail] = addValue;
            m_ready[m_tail] = addValueFlag;
            q.push_back(m_tail);
            m_tail = (m_tail + 1) % RS;
          end
          if (loadFlag) begin m_val[loadId] = loadValue; m_ready[loadId] = 1'b1; end
          if (rsFlag) begin m_val[rsId] = rsValue; m_ready[rsId] = 1'b1; end
        end
      end
      tick();
      n_checks++; if (clear !== e_clear || predictFlag !== e_pf || storeFlag !== e_sf || rfFlag !== e_rf) begin n_fail++; $display("FAIL rnd_flags c%0d: got %0b%0b%0b%02b expected %0b%0b%0b%02b", cyc, clear, predictFlag, storeFlag, rfFlag, e_clear, e_pf, e_sf, e_rf); end
      if (e_clear) begin
        n_checks++; if (setPCVal !== e_setpc) begin n_fail++; $display("FAIL rnd_pc c%0d: got %0h expected %0h", cyc, setPCVal, e_setpc); end
      end
      if (e_pf) begin
        n_checks++; if (predictAddr !== e_pa || predictVal !== e_pv) begin n_fail++; $display("FAIL rnd_pred c%0d: got %0h %0b expected %0h %0b", cyc, predictAddr, predictVal, e_pa, e_pv); end
      end
      if (e_sf) begin
        n_checks++; if (storeId !== e_sid) begin n_fail++; $display("FAIL rnd_sid c%0d: got %0d expected %0d", cyc, storeId, e_sid); end
      end
      if (e_rf[0]) begin
        n_checks++; if (rfRobId[3:0] !== e_rid[0] || rfDest[4:0] !== e_rd[0] || rfValue[31:0] !== e_rv[0]) begin n_fail++; $display("FAIL rnd_rf0 c%0d: got %0h %0h %0h expected %0h %0h %0h", cyc, rfRobId[3:0], rfDest[4:0], rfValue[31:0], e_rid[0], e_rd[0], e_rv[0]); end
      end
      if (e_rf[1]) begin
        n_checks++; if (rfRobId[7:4] !== e_rid[1] || rfDest[9:5] !== e_rd[1] || rfValue[63:32] !== e_rv[1]) begin n_fail++; $display("FAIL rnd_rf1 c%0d: got %0h %0h %0h expected %0h %0h %0h", cyc, rfRobId[7:4], rfDest[9:5], rfValue[63:32], e_rid[1], e_rd[1], e_rv[1]); end
      end
    end
    idle();
  endtask

  initial begin
    resetIn = 1'b0;
    idle();
    test_reset();
    test_fill_full();
    test_bypass();
    test_dual_commit();
    test_store_backpressure();
    test_branch_flush();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_commit_rob.md
Name: multi_commit_rob

Overview:
- Parametrised second-generation reorder buffer. Entries are allocated in program order from the instruction unit and filled out of order by RS and LSB writebacks.
- Retires up to two entries per cycle, in order, to the register file, predictor and LSB.
- On a branch mispredict it drives a registered clear and redirect PC.
- New relative to the single-commit ROB: count-based occupancy, dual commit, same-cycle writeback bypass on operand lookup, and store-commit backpressure from the LSB.

Parameters:
- ROB_WIDTH, 4, log2 of entry count; depth ROB_SIZE = 2**ROB_WIDTH, minimum 2.
- DUAL_COMMIT, 1, 1 enables the second commit slot; 0 makes slot 1 outputs constant 0.

Ports:
- clockIn input 1: the single clock.
- resetIn input 1: synchronous, active-high reset.
- readyIn input 1: global enable; when 0, all state holds.
- clear output 1: registered flush pulse on branch mispredict.
- setPCVal output 32: redirect PC, valid while clear=1.
- addFlag input 1: allocate request.
- addType input 2: 00 OTHER, 10 BRANCH, 11 STORE.
- addDest input 5: destination register.
- addJump input 1: predicted taken.
- addPC input 32: recovery PC.
- addInsAddr input 32: instruction address.
- addValueFlag input 1: value is known at allocate.
- addValue input 32: that value.
- freeId output ROB_WIDTH: tail index.
- full output 1: count == ROB_SIZE.
- count output ROB_WIDTH+1: current occupancy.
- rs1Id, rs2Id input ROB_WIDTH: operand lookup ids.
- rs1Busy, rs2Busy output 1: entry not ready.
- rs1Val, rs2Val output 32: entry value.
- rsFlag input 1, rsId input ROB_WIDTH, rsValue input 32: ALU writeback.
- loadFlag input 1, loadId input ROB_WIDTH, loadValue input 32: load writeback.
- predictFlag output 1: predictor update valid.
- predictAddr output 32: address of the committed branch.
- predictVal output 1: actual taken outcome.
- rfFlag output 2: per-slot register-file commit valid.
- rfRobId output 2*ROB_WIDTH: per-slot ROB id.
- rfDest output 10: per-slot destination.
- rfValue output 64: per-slot value; slot0 occupies the low bits of each bus.
- storeFlag output 1: store commit pulse.
- storeId output ROB_WIDTH: id of the committed store.
- storeAccept input 1: LSB can take a store commit this cycle.
- headId output ROB_WIDTH: head index.

Behaviour:
- Reset: when resetIn=1, or when clear=1 and readyIn=1, at the clock edge:
  - head, tail, count and all busy/ready bits go to 0.
  - All registered outputs go to 0: clear, setPCVal, predictFlag, rfFlag, storeFlag, and every id/addr/dest/value register.
- Hold: readyIn=0 holds all state. Reset takes priority over readyIn.
- Allocate: when addFlag=1 and full=0:
  - Write the entry at tail; ready = addValueFlag.
  - tail increments modulo ROB_SIZE.
  - addFlag while full is ignored, with no state change.
- Writeback: rsFlag and loadFlag may both fire in the same cycle to different ids; each sets value and ready on its id.
  - Writeback to an id being allocated in the same cycle is illegal (the bench does not drive it).
- Operand bypass (combinational): if rsFlag (or loadFlag) targets rsXId this cycle, rsXBusy=0 and rsXVal is the incoming value. rsFlag wins if both target the same id.
- Commit slot0 fires when head is busy and ready. If the type is STORE, storeAccept=1 is also required; otherwise the entry stalls at head.
- Commit slot1 (DUAL_COMMIT=1) fires when all of the following hold:
  - slot0 commits and slot0 type is OTHER;
  - head+1 (wrapping) is busy and ready;
  - its type is OTHER, or STORE with storeAccept=1.
  - A BRANCH never commits in slot1.
- Per-type outputs, registered one cycle after the commit decision:
  - OTHER: rfFlag[k]=1 with id, dest and value of the entry.
  - STORE: storeFlag=1 with storeId.
  - BRANCH (slot0 only): predictFlag=1, predictAddr=insAddr, predictVal=value[0]. clear = value[0] XOR jump; setPCVal = the entry's PC.
- Non-committing slots drive their flags to 0 next cycle. Flags are single-cycle pulses.
- head advances by the number committed (0, 1 or 2), modulo ROB_SIZE.
- count next = count + alloc − commits. Simultaneous allocate and commit when full: commit frees space next cycle only; allocation is refused this cycle because full is evaluated on current count.
- Wrap-around: head/tail indices wrap naturally; the slot1 index is (head+1) mod ROB_SIZE.
- A committed entry is not visible to operand lookup as busy; the instruction unit resolves from the register file.

Test Plan:
- Reset, then allocate 16 OTHER entries with ROB_WIDTH=4 and addValueFlag=0 → full=1 and count=16; a 17th addFlag is ignored and tail stays 0.
- Writeback rsId=3 with 0xDEAD_BEEF while rs1Id=3 in the same cycle → rs1Busy=0 and rs1Val=0xDEADBEEF combinationally.
- Ready OTHER entries at ids 0 and 1 → the next cycle shows rfFlag=2'b11 with rfRobId slots 0 and 1, and head=2, count decreases by 2.
- Head is STORE, ready, with storeAccept=0 for 3 cycles, then 1 → storeFlag stays 0 for 3 cycles, then pulses once with storeId=head.
- BRANCH at head with jump=0, value=1, PC=0x104 → clear=1 and setPCVal=0x104 next cycle; the following edge has head=tail=count=0 and all flags 0.
- Fill until head=15, then commit ids 15 and 0 together → slot1 uses id 0 and head wraps to 1.
